am_insertion_core: RTL and testbench

//  Alignment-marker insertion stage of the 1.6T AUI TX path. Takes two scrambled
//  257-bit block flows, packs each into a 10280-bit word (40 slots x 257 b) and puts
//  an AM block in slot 0 of every AM_PERIOD_WORDS-th word. Sits between the x85

---
 rtl/aui_pkg.sv | 24 ++
 rtl/am_flow_packer.sv | 64 ++++++
 rtl/am_insertion_core.sv | 99 +++++++++
 tb/tb_am_insertion_core.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aui_pkg.sv
//------------------------------------------------------------------------------
// Module  : aui_pkg
// Brief   : Shared widths, AM patterns and block/word types for the AUI TX path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aui_pkg;

    localparam int unsigned BITS_BLOCK      = 257;
    localparam int unsigned BLOCKS_PER_WORD = 40;
    localparam int unsigned AM_MAPPED_WIDTH = BITS_BLOCK * BLOCKS_PER_WORD;
    localparam int unsigned SLOT_W          = $clog2(BLOCKS_PER_WORD);

    typedef logic [BITS_BLOCK-1:0]      block_t;
    typedef logic [AM_MAPPED_WIDTH-1:0] word_t;
    typedef logic [SLOT_W-1:0]          slot_t;

    localparam block_t AM_F0 = {1'b1, {32{8'hC1}}};
    localparam block_t AM_F1 = {1'b1, {32{8'h3E}}};

endpackage

`default_nettype wire

// File: rtl/am_flow_packer.sv
//------------------------------------------------------------------------------
// Module  : am_flow_packer
// Brief   : Packs one 257-bit block flow into 40-slot words, AM pattern in slot 0
//           when requested; output word is registered on the completing block.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module am_flow_packer
    import aui_pkg::*;
#(
    parameter block_t AM_PATTERN = AM_F0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   wr_en_i,
    input  slot_t  slot_idx_i,
    input  logic   am_slot_i,
    input  logic   complete_i,
    input  block_t block_i,
    output word_t  word_o
);

    word_t merged;
    word_t word_q;

    // The last slot is never stored: the completing block is merged straight
    // into the output register.
    for (genvar k = 0; k < BLOCKS_PER_WORD; k++) begin : g_slot
        if (k < BLOCKS_PER_WORD - 1) begin : g_acc
            block_t slot_q;
            logic   hit;
            block_t wdata;

            assign hit   = wr_en_i && (am_slot_i ? (k < 2) : (slot_idx_i == slot_t'(k)));
            assign wdata = (am_slot_i && (k == 0)) ? AM_PATTERN : block_i;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q <= '0;
                end else if (hit) begin
                    slot_q <= wdata;
                end
            end

            assign merged[k*BITS_BLOCK +: BITS_BLOCK] = slot_q;
        end else begin : g_last
            assign merged[k*BITS_BLOCK +: BITS_BLOCK] = block_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (complete_i) begin
            word_q <= merged;
        end
    end

    assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/am_insertion_core.sv
//------------------------------------------------------------------------------
// Module  : am_insertion_core
// Brief   : Alignment-marker insertion for two scrambled 257-bit flows; emits a
//           10280-bit word per flow with an AM block every AM_PERIOD_WORDS words.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module am_insertion_core
    import aui_pkg::*;
#(
    parameter int unsigned AM_PERIOD_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [BITS_BLOCK-1:0]      flow_0,
    input  logic [BITS_BLOCK-1:0]      flow_1,
    output logic [AM_MAPPED_WIDTH-1:0] tx_scrambled_f0,
    output logic [AM_MAPPED_WIDTH-1:0] tx_scrambled_f1,
    output logic                       valid_signal
);

    localparam int unsigned WCNT_W = (AM_PERIOD_WORDS > 1) ? $clog2(AM_PERIOD_WORDS) : 1;

    typedef logic [WCNT_W-1:0] wcnt_t;

    localparam wcnt_t WCNT_LAST = wcnt_t'(AM_PERIOD_WORDS - 1);
    localparam slot_t SLOT_LAST = slot_t'(BLOCKS_PER_WORD - 1);

    slot_t slot_cnt_q, slot_cnt_d;
    wcnt_t word_cnt_q, word_cnt_d;
    logic  valid_q, valid_d;
    logic  am_slot;
    logic  complete;

    // AM is inserted together with the first data block of an AM word.
    assign am_slot  = (word_cnt_q == '0) && (slot_cnt_q == '0);
    assign complete = i_valid && (slot_cnt_q == SLOT_LAST);

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        word_cnt_d = word_cnt_q;
        valid_d    = complete;
        if (i_valid) begin
            if (complete) begin
                slot_cnt_d = '0;
                word_cnt_d = (word_cnt_q == WCNT_LAST) ? '0 : word_cnt_q + wcnt_t'(1);
            end else if (am_slot) begin
                slot_cnt_d = slot_t'(2);
            end else begin
                slot_cnt_d = slot_cnt_q + slot_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            word_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            word_cnt_q <= word_cnt_d;
            valid_q    <= valid_d;
        end
    end

    assign valid_signal = valid_q;

    am_flow_packer #(
        .AM_PATTERN (AM_F0)
    ) u_pack_f0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (i_valid),
        .slot_idx_i (slot_cnt_q),
        .am_slot_i  (am_slot),
        .complete_i (complete),
        .block_i    (flow_0),
        .word_o     (tx_scrambled_f0)
    );

    am_flow_packer #(
        .AM_PATTERN (AM_F1)
    ) u_pack_f1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (i_valid),
        .slot_idx_i (slot_cnt_q),
        .am_slot_i  (am_slot),
        .complete_i (complete),
        .block_i    (flow_1),
        .word_o     (tx_scrambled_f1)
    );

endmodule

`default_nettype wire

// File: tb/tb_am_insertion_core.sv
//------------------------------------------------------------------------------
// Module  : tb_am_insertion_core
// Brief   : Directed self-checking bench for am_insertion_core.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_am_insertion_core;

    localparam int BB = 257;
    localparam int NS = 40;
    localparam int WW = BB * NS;
    localparam logic [BB-1:0] EXP_AM_F0 = {1'b1, {32{8'hC1}}};
    localparam logic [BB-1:0] EXP_AM_F1 = {1'b1, {32{8'h3E}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [BB-1:0] flow_0;
    logic [BB-1:0] flow_1;
    logic [WW-1:0] tx_f0;
    logic [WW-1:0] tx_f1;
    logic          valid_signal;

    int n_cmp = 0;
    int n_bad = 0;
    logic          mon_en = 1'b0;
    logic          prev_vs = 1'b0;
    logic [WW-1:0] held_f0 = '0;
    logic [WW-1:0] held_f1 = '0;

    always #5 clk = ~clk;

    am_insertion_core #(
        .AM_PERIOD_WORDS (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .flow_0          (flow_0),
        .flow_1          (flow_1),
        .tx_scrambled_f0 (tx_f0),
        .tx_scrambled_f1 (tx_f1),
        .valid_signal    (valid_signal)
    );

    task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [BB-1:0] a, input logic [BB-1:0] b);
        i_valid = v;
        flow_0  = a;
        flow_1  = b;
        @(posedge clk);
        #1;
    endtask

    // Feed n blocks starting at value base; optionally an idle cycle after each.
    task automatic feed(input int base, input int n, input bit gaps, input bit completes);
        logic [BB-1:0] v;
        for (int j = 0; j < n; j++) begin
            v = BB'(base + j);
            step(1'b1, v, ~v);
            chk($sformatf("vs_%0d_%0d", base, j), BB'(valid_signal),
                BB'((completes && (j == n - 1)) ? 1 : 0));
            if (gaps) begin
                step(1'b0, '1, '1);
                chk($sformatf("vs_gap_%0d_%0d", base, j), BB'(valid_signal), '0);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input bit am, input int base);
        logic [BB-1:0] e0;
        for (int k = 0; k < NS; k++) begin
            if (am) e0 = (k == 0) ? EXP_AM_F0 : BB'(base + k - 1);
            else    e0 = BB'(base + k);
            chk($sformatf("%s_f0_s%0d", tag, k), tx_f0[k*BB +: BB], e0);
            if (am && k == 0) chk($sformatf("%s_f1_s0", tag), tx_f1[0 +: BB], EXP_AM_F1);
            else              chk($sformatf("%s_f1_s%0d", tag, k), tx_f1[k*BB +: BB], ~e0);
        end
    endtask

    task automatic hold_reset(input int cycles, input logic v);
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int c = 0; c < cycles; c++) step(v, BB'(77), BB'(88));
        chk("rst_vs", BB'(valid_signal), '0);
        chk("rst_f0_zero", BB'(tx_f0 == '0), BB'(1));
        chk("rst_f1_zero", BB'(tx_f1 == '0), BB'(1));
        rst = 1'b0;
        step(1'b0, '0, '0);
        mon_en = 1'b1;
    endtask

    // Pulse-width and output-stability watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_double_pulse", BB'(valid_signal & prev_vs), '0);
            if (!valid_signal) begin
                chk("f0_stable", BB'(tx_f0 == held_f0), BB'(1));
                chk("f1_stable", BB'(tx_f1 == held_f1), BB'(1));
            end
        end
        if (valid_signal || !mon_en) begin
            held_f0 = tx_f0;
            held_f1 = tx_f1;
        end
        prev_vs = valid_signal;
    end

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        flow_0  = '0;
        flow_1  = '0;

        // Reset, with i_valid asserted during it; no blocks may be counted.
        for (int c = 0; c < 2; c++) step(1'b0, '0, '0);
        hold_reset(3, 1'b1);

        // AM word followed by three data words, then the wrap back to AM.
        feed(0, 39, 1'b0, 1'b1);
        check_word("w0_am", 1'b1, 0);
        feed(39, 40, 1'b0, 1'b1);
        check_word("w1", 1'b0, 39);
        feed(79, 40, 1'b0, 1'b1);
        check_word("w2", 1'b0, 79);
        feed(119, 40, 1'b0, 1'b1);
        check_word("w3", 1'b0, 119);
        feed(159, 39, 1'b0, 1'b1);
        check_word("w4_am", 1'b1, 159);

        // Gapped input must give the same AM word.
        hold_reset(2, 1'b0);
        feed(0, 39, 1'b1, 1'b1);
        check_word("gap_am", 1'b1, 0);

        // Reset mid-word discards the partial word.
        feed(1000, 20, 1'b0, 1'b0);
        hold_reset(2, 1'b1);
        feed(500, 39, 1'b0, 1'b1);
        check_word("post_rst_am", 1'b1, 500);

        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
